// File: rtl/key_debounce_repeat.sv
// -----------------------------------------------------------------------------
// key_debounce_repeat
//
// Conditions one raw board push-button for the digit/mode counter that drives
// the 7-segment display. The raw pin is synchronised, sampled on a slow tick,
// debounced, and turned into single-cycle event pulses. The downstream counter
// increments on press_pulse, so one physical press gives exactly one count.
// Auto-repeat pulses follow while the button stays held.
//
// Parameters
//   TICK_DIV            clk_50mhz cycles per sample tick (500000 -> 10 ms)
//   STABLE_TICKS        consecutive agreeing samples to accept press/release
//                       (1..15)
//   REPEAT_DELAY_TICKS  held ticks after acceptance before auto-repeat (>= 1)
//   REPEAT_RATE_TICKS   ticks between auto-repeat pulses (>= 1)
//   REPEAT_EN           0 disables auto-repeat and long_press
//
// Ports
//   clk_50mhz      in   system clock, 50 MHz
//   rst            in   synchronous reset, active-high
//   btn_in         in   raw asynchronous button, active-high
//   press_pulse    out  one-cycle pulse: debounced press or auto-repeat
//   release_pulse  out  one-cycle pulse on debounced release
//   btn_level      out  debounced button level
//   long_press     out  high while in auto-repeat
// -----------------------------------------------------------------------------
module key_debounce_repeat #(
  parameter int TICK_DIV           = 500000,
  parameter int STABLE_TICKS       = 2,
  parameter int REPEAT_DELAY_TICKS = 50,
  parameter int REPEAT_RATE_TICKS  = 10,
  parameter bit REPEAT_EN          = 1'b1
) (
  input  logic clk_50mhz,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic btn_level,
  output logic long_press
);

  // ---------------------------------------------------------------------------
  // Counter widths, sized so that each counter can hold its terminal value
  // without wrapping.
  // ---------------------------------------------------------------------------
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STAB_W = $clog2(STABLE_TICKS + 1);
  localparam int HOLD_W = $clog2(REPEAT_DELAY_TICKS + 1);
  localparam int RPT_W  = $clog2(REPEAT_RATE_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_TICKS);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(REPEAT_DELAY_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [RPT_W-1:0]  RPT_MAX   = RPT_W'(REPEAT_RATE_TICKS);
  localparam logic [RPT_W-1:0]  RPT_ONE   = RPT_W'(1);

  // A single agreeing sample is enough: skip the ARMING/RELEASING states.
  localparam bit SINGLE_SAMPLE = (STABLE_TICKS == 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMING    = 3'd1,
    ST_HELD      = 3'd2,
    ST_REPEAT    = 3'd3,
    ST_RELEASING = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. "s" is the only view of the button the FSM uses.
  // ---------------------------------------------------------------------------
  logic sync_q1;
  logic s;

  // NOTE: every clocked block uses non-blocking assignments so that all flops
  // sample their inputs from the same edge; blocking here would collapse the
  // two synchroniser stages into one.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      s       <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      s       <= sync_q1;
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running sample tick. Button activity never restarts it, so the
  // sampling grid is fixed relative to reset.
  // ---------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce / repeat FSM.
  //   stab_cnt    counts agreeing samples while ARMING or RELEASING
  //   hold_cnt    held ticks since acceptance (saturates at the repeat delay)
  //   rpt_cnt     ticks since the last auto-repeat pulse
  //   from_repeat where a RELEASING glitch returns to (1 = REPEAT, 0 = HELD)
  // All outputs are registered, so pulses appear the cycle after their tick.
  // ---------------------------------------------------------------------------
  state_t            state,       state_nx;
  logic [STAB_W-1:0] stab_cnt,    stab_nx;
  logic [HOLD_W-1:0] hold_cnt,    hold_nx;
  logic [RPT_W-1:0]  rpt_cnt,     rpt_nx;
  logic              from_repeat, origin_nx;
  logic              press_nx;
  logic              release_nx;
  logic              level_nx;
  logic              long_nx;

  logic [STAB_W-1:0] stab_inc;
  logic [HOLD_W-1:0] hold_inc;
  logic [RPT_W-1:0]  rpt_inc;

  assign stab_inc = stab_cnt + STAB_ONE;
  assign hold_inc = hold_cnt + HOLD_ONE;
  assign rpt_inc  = rpt_cnt + RPT_ONE;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state         <= ST_IDLE;
      stab_cnt      <= '0;
      hold_cnt      <= '0;
      rpt_cnt       <= '0;
      from_repeat   <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      btn_level     <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_nx;
      stab_cnt      <= stab_nx;
      hold_cnt      <= hold_nx;
      rpt_cnt       <= rpt_nx;
      from_repeat   <= origin_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      btn_level     <= level_nx;
      long_press    <= long_nx;
    end
  end

  always_comb begin
    // NOTE: every signal written below gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    state_nx   = state;
    stab_nx    = stab_cnt;
    hold_nx    = hold_cnt;
    rpt_nx     = rpt_cnt;
    origin_nx  = from_repeat;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    level_nx   = btn_level;
    long_nx    = long_press;

    if (tick) begin
      unique case (state)
        ST_IDLE: begin
          if (s) begin
            if (SINGLE_SAMPLE) begin
              state_nx = ST_HELD;
              stab_nx  = '0;
              hold_nx  = '0;
              press_nx = 1'b1;
              level_nx = 1'b1;
            end else begin
              state_nx = ST_ARMING;
              stab_nx  = STAB_ONE;
            end
          end
        end

        ST_ARMING: begin
          if (s) begin
            if (stab_inc == STAB_MAX) begin
              state_nx = ST_HELD;
              stab_nx  = '0;
              hold_nx  = '0;
              press_nx = 1'b1;
              level_nx = 1'b1;
            end else begin
              stab_nx = stab_inc;
            end
          end else begin
            // Not stable long enough: silently forget the attempt.
            state_nx = ST_IDLE;
            stab_nx  = '0;
          end
        end

        ST_HELD: begin
          if (s) begin
            // Without auto-repeat the counter parks at the delay value
            // instead of wrapping.
            if (hold_cnt != HOLD_MAX) begin
              hold_nx = hold_inc;
              if (REPEAT_EN && (hold_inc == HOLD_MAX)) begin
                state_nx = ST_REPEAT;
                rpt_nx   = '0;
                press_nx = 1'b1;
                long_nx  = 1'b1;
              end
            end
          end else if (SINGLE_SAMPLE) begin
            state_nx   = ST_IDLE;
            stab_nx    = '0;
            hold_nx    = '0;
            rpt_nx     = '0;
            release_nx = 1'b1;
            level_nx   = 1'b0;
            long_nx    = 1'b0;
          end else begin
            state_nx  = ST_RELEASING;
            stab_nx   = STAB_ONE;
            origin_nx = 1'b0;
          end
        end

        ST_REPEAT: begin
          if (s) begin
            if (rpt_inc == RPT_MAX) begin
              rpt_nx   = '0;
              press_nx = 1'b1;
            end else begin
              rpt_nx = rpt_inc;
            end
          end else if (SINGLE_SAMPLE) begin
            state_nx   = ST_IDLE;
            stab_nx    = '0;
            hold_nx    = '0;
            rpt_nx     = '0;
            release_nx = 1'b1;
            level_nx   = 1'b0;
            long_nx    = 1'b0;
          end else begin
            state_nx  = ST_RELEASING;
            stab_nx   = STAB_ONE;
            origin_nx = 1'b1;
          end
        end

        ST_RELEASING: begin
          // btn_level and long_press hold their values here, so a short low
          // glitch is invisible downstream.
          if (!s) begin
            if (stab_inc == STAB_MAX) begin
              state_nx   = ST_IDLE;
              stab_nx    = '0;
              hold_nx    = '0;
              rpt_nx     = '0;
              release_nx = 1'b1;
              level_nx   = 1'b0;
              long_nx    = 1'b0;
            end else begin
              stab_nx = stab_inc;
            end
          end else begin
            // Glitch: resume where we left off. hold_cnt and rpt_cnt are left
            // untouched so the repeat cadence is not restarted.
            state_nx = from_repeat ? ST_REPEAT : ST_HELD;
            stab_nx  = '0;
          end
        end

        default: begin
          state_nx = ST_IDLE;
          stab_nx  = '0;
          hold_nx  = '0;
          rpt_nx   = '0;
          level_nx = 1'b0;
          long_nx  = 1'b0;
        end
      endcase
    end
  end

endmodule
